// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard unit and its scoreboard.
package hazard_pkg;

    localparam int MAX_DEPTH = 7;
    localparam int FWD_REGFILE = 0;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } sb_entry_t;

    // Index k holds stage k; index 0 is never valid so a stage number
    // can be used directly as an index without range guards.
    typedef sb_entry_t [MAX_DEPTH:0] sb_vec_t;

    // Returns the smallest stage whose valid entry writes rs, or 0 if none.
    // Scanning from oldest to youngest lets the youngest match overwrite.
    function automatic logic [2:0] match_youngest(input sb_vec_t sb,
                                                  input logic [4:0] rs,
                                                  input logic used);
        logic [2:0] hit;
        hit = 3'(FWD_REGFILE);
        if (used && rs != 5'd0) begin
            for (int k = MAX_DEPTH; k >= 1; k--) begin
                if (sb[k].valid && sb[k].rd == rs) begin
                    hit = 3'(k);
                end
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Decode-stage hazard request and the forwarding/stall/flush response.
interface hazard_unit_if #(parameter int FWD_W = 2);

    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [4:0]       id_rd;
    logic             id_reg_write;
    logic             id_is_load;
    logic             id_br_taken;
    logic [FWD_W-1:0] fwd_sel_a;
    logic [FWD_W-1:0] fwd_sel_b;
    logic             stall;
    logic             flush;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_is_load, id_br_taken,
        input  fwd_sel_a, fwd_sel_b, stall, flush
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_is_load, id_br_taken,
        output fwd_sel_a, fwd_sel_b, stall, flush
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// DEPTH-stage shift register of in-flight destination registers.
// It never freezes: a non-issuing cycle simply shifts in a bubble.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue,
    input  logic [4:0] rd,
    input  logic       reg_write,
    input  logic       is_load,
    output sb_vec_t    sb
);

    sb_entry_t [DEPTH:1] ent;
    sb_entry_t           new_ent;

    // Build the stage-1 entry; x0 writes and non-writers become bubbles.
    always_comb begin
        new_ent         = '0;
        new_ent.valid   = issue && reg_write && (rd != 5'd0);
        new_ent.rd      = rd;
        new_ent.is_load = is_load;
        if (!new_ent.valid) begin
            new_ent = '0;
        end
    end

    // Advance every entry one stage per cycle; the last stage retires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent <= '0;
        end else begin
            ent[1] <= new_ent;
            for (int k = 2; k <= DEPTH; k++) begin
                ent[k] <= ent[k-1];
            end
        end
    end

    // Present the entries on a fixed-size vector padded with invalid stages.
    always_comb begin
        sb = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            sb[k] = ent[k];
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Operand forwarding, load-use stall and post-branch flush generation.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int LOAD_STAGE   = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int FWD_W        = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    hazard_unit_if.slave hz
);

    localparam logic [2:0] LOAD_K  = 3'(LOAD_STAGE);
    localparam logic [2:0] FLUSH_K = 3'(FLUSH_CYCLES);

    sb_vec_t    sb;
    logic [2:0] win_a;
    logic [2:0] win_b;
    logic       load_hit_a;
    logic       load_hit_b;
    logic       stall;
    logic       flush;
    logic       issue;
    logic       br_accept;
    logic [2:0] flush_cnt;

    hazard_scoreboard #(.DEPTH(DEPTH)) u_sb (
        .clk       (clk),
        .reset     (reset),
        .issue     (issue),
        .rd        (hz.id_rd),
        .reg_write (hz.id_reg_write),
        .is_load   (hz.id_is_load),
        .sb        (sb)
    );

    // Youngest producer per operand, then the load-use hazard check.
    always_comb begin
        win_a      = match_youngest(sb, hz.id_rs1, hz.id_rs1_used);
        win_b      = match_youngest(sb, hz.id_rs2, hz.id_rs2_used);
        load_hit_a = (win_a != 3'd0) && sb[win_a].is_load && (win_a < LOAD_K);
        load_hit_b = (win_b != 3'd0) && sb[win_b].is_load && (win_b < LOAD_K);
        flush      = (flush_cnt != 3'd0);
        stall      = hz.id_valid && !flush && (load_hit_a || load_hit_b);
        issue      = hz.id_valid && !stall && !flush;
        br_accept  = issue && hz.id_br_taken;
    end

    // Drive the response; forwarding is meaningless for a dead decode slot.
    always_comb begin
        hz.fwd_sel_a = FWD_W'(FWD_REGFILE);
        hz.fwd_sel_b = FWD_W'(FWD_REGFILE);
        if (hz.id_valid && !flush) begin
            hz.fwd_sel_a = FWD_W'(win_a);
            hz.fwd_sel_b = FWD_W'(win_b);
        end
        hz.stall = stall;
        hz.flush = flush;
    end

    // Flush down-counter: loaded on an accepted taken branch, then drains.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_cnt <= 3'd0;
        end else if (br_accept) begin
            flush_cnt <= FLUSH_K;
        end else if (flush_cnt != 3'd0) begin
            flush_cnt <= flush_cnt - 3'd1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    typedef struct {
        string      name;
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       br;
        logic [1:0] ea;
        logic [1:0] eb;
        logic       es;
        logic       ef;
    } vec_t;

    typedef struct {
        string      name;
        logic [1:0] ea;
        logic [1:0] eb;
        logic       es;
        logic       ef;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    exp_t exp_q[$];
    vec_t tbl[$];

    hazard_unit_if #(.FWD_W(2)) hif ();

    hazard_unit #(
        .DEPTH        (2),
        .LOAD_STAGE   (2),
        .FLUSH_CYCLES (2),
        .FWD_W        (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input string name, input logic v,
                                input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2,
                                input logic [4:0] rd, input logic rw,
                                input logic ld, input logic br,
                                input logic [1:0] ea, input logic [1:0] eb,
                                input logic es, input logic ef);
        vec_t r;
        r.name = name; r.v = v; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
        r.rd = rd; r.rw = rw; r.ld = ld; r.br = br;
        r.ea = ea; r.eb = eb; r.es = es; r.ef = ef;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        exp_t e;
        hif.id_valid     = v.v;
        hif.id_rs1       = v.rs1;
        hif.id_rs1_used  = v.u1;
        hif.id_rs2       = v.rs2;
        hif.id_rs2_used  = v.u2;
        hif.id_rd        = v.rd;
        hif.id_reg_write = v.rw;
        hif.id_is_load   = v.ld;
        hif.id_br_taken  = v.br;
        e.name = v.name; e.ea = v.ea; e.eb = v.eb; e.es = v.es; e.ef = v.ef;
        exp_q.push_back(e);
    endtask

    task automatic cmp(input string nm, input string fld, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty actual=0 required=1");
        end else begin
            e = exp_q.pop_front();
            cmp(e.name, "fwd_sel_a", int'(hif.fwd_sel_a), int'(e.ea));
            cmp(e.name, "fwd_sel_b", int'(hif.fwd_sel_b), int'(e.eb));
            cmp(e.name, "stall",     int'(hif.stall),     int'(e.es));
            cmp(e.name, "flush",     int'(hif.flush),     int'(e.ef));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        //           name            v  rs1 u1 rs2 u2  rd rw ld br  ea eb es ef
        tbl.push_back(mk("first_cyc",  1, 5,  1, 5,  1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("add_x5",     1, 1,  1, 2,  1, 5, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("b2b_alu",    1, 5,  1, 5,  1, 6, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk("x5_stage2",  1, 5,  1, 0,  0, 0, 1, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk("idle0",      0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("lw_x7",      1, 1,  1, 0,  0, 7, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("lu_stall",   1, 7,  1, 1,  1, 8, 1, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk("lu_release", 1, 7,  1, 1,  1, 8, 1, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk("addi_x3_a",  1, 0,  1, 0,  0, 3, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("addi_x3_b",  1, 0,  1, 0,  0, 3, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("youngest",   1, 3,  1, 3,  1, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk("addi_x0",    1, 3,  1, 0,  0, 0, 1, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk("read_x0",    1, 0,  1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("beq_take",   1, 1,  1, 2,  1, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("br_in_fl1",  1, 1,  1, 2,  1, 9, 1, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk("fl2",        1, 9,  1, 9,  1, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("no_iss_fl",  1, 9,  1, 9,  1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("lw_x10",     1, 1,  1, 0,  0,10, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("br_stall",   1,10,  1, 2,  1, 0, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk("br_repres",  1,10,  1, 2,  1, 0, 0, 0, 1, 2, 0, 0, 0));
        tbl.push_back(mk("br_fl1",     0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("br_fl2",     0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("br_fl_end",  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));

        reset = 1'b0;
        drive(mk("in_reset", 1, 5, 1, 5, 1, 5, 1, 1, 1, 0, 0, 0, 0));
        #3;
        check_out();
        @(negedge clk);
        drive(mk("in_reset2", 1, 5, 1, 5, 1, 5, 1, 1, 1, 0, 0, 0, 0));
        #3;
        check_out();
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i]);
            #3;
            check_out();
            @(negedge clk);
        end

        // Reset in the middle of a flush
        drive(mk("lw_br_x11",  1, 1, 1, 0, 0, 11, 1, 1, 1, 0, 0, 0, 0));
        #3; check_out(); @(negedge clk);
        drive(mk("mid_flush",  1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        #3; check_out();
        #1; reset = 1'b0;
        drive(mk("rst_flush",  1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1; check_out();
        @(negedge clk);
        reset = 1'b1;
        drive(mk("post_rst_a", 1, 11, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #3; check_out(); @(negedge clk);

        // Reset in the middle of a load-use stall
        drive(mk("lw_x12",     1, 1, 1, 0, 0, 12, 1, 1, 0, 0, 0, 0, 0));
        #3; check_out(); @(negedge clk);
        drive(mk("mid_stall",  1, 12, 1, 0, 0, 13, 1, 0, 0, 1, 0, 1, 0));
        #3; check_out();
        #1; reset = 1'b0;
        drive(mk("rst_stall",  1, 12, 1, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0));
        #1; check_out();
        @(negedge clk);
        reset = 1'b1;
        drive(mk("post_rst_b", 1, 12, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #3; check_out(); @(negedge clk);

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL leftover_expected actual=%0d required=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
